reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Parametrised operand-hazard unit for the decode stage. It generalises the fixed ex/mem/wb bypass and load-use stall to NFWD producer ports and NSRC source operands. Per-register pending-write counters track in-flight writers, which covers multi-cycle units (mul/div, variable-latency loads) that have no bypass port. Outputs are resolved operand values plus a single issue-ready handshake toward the EX stage.

Parameters:
NREG, 32, architectural register count
AW, 5, register address width (log2 NREG)
DW, 32, data width
NSRC, 2, source operands per instruction
NFWD, 3, bypass producer ports; index 0 = youngest stage (priority)
CNT_W, 2, pending-counter width; max outstanding writes per reg = 2^CNT_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill all in-flight writers (branch/exception)
issue_valid  in  1  decode holds a valid instruction
issue_ready  out  1  instruction may issue this cycle
issue_we  in  1  instruction writes a GPR
issue_dest  in  AW  destination register
src_need  in  NSRC  per-source operand-required flag
src_addr  in  NSRC*AW  source register addresses
rf_rdata  in  NSRC*DW  regfile read data, aligned to src_addr
src_value  out  NSRC*DW  resolved operand values
fwd_valid  in  NFWD  producer holds a valid GPR-writing instruction
fwd_addr  in  NFWD*AW  producer destination
fwd_data  in  NFWD*DW  producer result
fwd_data_ok  in  NFWD  result available now (0 for a load still in EX, for example)
ret_valid  in  1  writeback retires a GPR write this cycle
ret_addr  in  AW  retired destination
sb_err  out  1  sticky: retire hit a zero counter

Behaviour:
- State: cnt[NREG], CNT_W bits each. Reset and flush both clear every cnt to 0. Reset also clears sb_err to 0. Outputs after reset: issue_ready reflects comb logic; src_value is the mux result.
- Issue fires when issue_valid & issue_ready. On fire with issue_we and issue_dest!=0, cnt[issue_dest] increments.
- Retire: ret_valid with ret_addr!=0 decrements cnt[ret_addr].
- Issue and retire on the same reg in the same cycle: count unchanged.
- Retire when the count is 0: count stays 0 and sb_err sets. Only reset clears sb_err.
- Register 0: never counted, never stalls, src_value = 0.
- Per source s, all combinational:
  - Match search picks the lowest i with fwd_valid[i] & fwd_addr[i]==src_addr[s] & src_addr[s]!=0.
  - Match found with fwd_data_ok: value = fwd_data[i], no stall.
  - Match found without fwd_data_ok: stall.
  - No match and cnt>0: stall, because the writer is in an unbypassed unit.
  - No match and cnt==0: value = rf_rdata[s]. The regfile is write-through, so writeback bypass is external.
  - Stall contributes only if src_need[s].
- issue_ready = ~any_stall & ~(issue_we & issue_dest!=0 & cnt[issue_dest]==max & ~(ret_valid & ret_addr==issue_dest)).
- Counter saturation therefore blocks issue rather than wrapping.
- Flush in the same cycle as an issue fire: flush wins and all counts become 0. Producers and writeback must suppress ret_valid for killed instructions from the cycle after flush.
- No sequential latency on the data path. Counters update at the next edge.

Optional Feature:
SB_STALL_CNT_EN
- Defined: adds output stall_cnt (32 bits). It increments each cycle issue_valid & ~issue_ready, saturates at 0xFFFFFFFF, and is cleared only by reset (not flush).
- Undefined: the port and the counter are absent.

Decomposition:
- Shared package/header (sb_pkg): AW, DW, NREG defaults, and the CNT_MAX localparam.
- Shared package/header also holds the packed-bus slice macros for src_addr/fwd_addr/fwd_data.
- One sub-module, sb_fwd_mux: per-source priority match plus value/stall select. It is instantiated NSRC times.
- The counter array stays in the top.

Test Plan:
1. After reset, issue add r3←r1,r2 with no producers: issue_ready=1, src_value=rf_rdata. Then cnt[3]=1.
2. fwd_valid[0]&[1] both addr=5: port0 data=0xAAAA, port1 data=0xBBBB, data_ok=1. Result: src_value=0xAAAA.
3. Load-use: fwd_valid[0], addr=4, data_ok=0, src_need=1. Result: issue_ready=0. Next cycle data_ok=1, data=0x1234: issue_ready=1, value 0x1234.
4. Div writer: issue r7 (cnt=1), producers empty, consumer of r7 stalls. Then ret_valid r7 arrives: cnt=0 next cycle, consumer issues with rf_rdata.
5. CNT_W=2: issue 3 writes to r9; the 4th is held (issue_ready=0) until a same-cycle retire of r9 arrives, then it fires and the count stays 3.
6. Flush with cnt[2]=2 plus simultaneous issue to r2: all counts 0. A following ret_valid r2 sets sb_err=1. Source r0 always returns 0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared defaults, operand-source encoding and packed-bus slice helpers for the
// register scoreboard.
`ifndef SB_PKG_SV
`define SB_PKG_SV

// Selects lane idx (width w) out of a flat packed bus.
`define SB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package sb_pkg;

  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int NSRC_DEF  = 2;
  localparam int NFWD_DEF  = 3;
  localparam int CNT_W_DEF = 2;
  localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FWD,
    SRC_RF,
    SRC_WAIT
  } src_sel_e;

endpackage

`endif

// File: rtl/sb_fwd_mux.sv
// Per-source operand resolver: priority bypass match across producer ports,
// then choose between bypass, regfile, hard zero, or a stall.
module sb_fwd_mux
  import sb_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NFWD = NFWD_DEF
) (
  input  logic             need,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    rf_data,
  input  logic [NFWD-1:0]  fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic [NFWD-1:0]  fwd_data_ok,
  input  logic             pending,
  output logic [DW-1:0]    value,
  output logic             stall
);

  logic          hit;
  logic          hit_ok;
  logic [DW-1:0] hit_data;
  src_sel_e      sel;

  // Walk from the oldest port down so the youngest matching port wins.
  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_data = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (`SB_SLICE(fwd_addr, i, AW) == addr)) begin
        hit      = 1'b1;
        hit_ok   = fwd_data_ok[i];
        hit_data = `SB_SLICE(fwd_data, i, DW);
      end
    end
  end

  always_comb begin
    sel = SRC_RF;
    if (addr == '0) begin
      sel = SRC_ZERO;
    end else if (hit && hit_ok) begin
      sel = SRC_FWD;
    end else if (hit || pending) begin
      sel = SRC_WAIT;
    end
  end

  always_comb begin
    value = rf_data;
    case (sel)
      SRC_ZERO: value = '0;
      SRC_FWD:  value = hit_data;
      default:  value = rf_data;
    endcase
  end

  assign stall = need & (sel == SRC_WAIT);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage operand hazard unit: pending-write counters per register plus
// NSRC bypass muxes. Optional stall counter enabled by SB_STALL_CNT_EN.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int NFWD  = NFWD_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_we,
  input  logic [AW-1:0]       issue_dest,
  input  logic [NSRC-1:0]     src_need,
  input  logic [NSRC*AW-1:0]  src_addr,
  input  logic [NSRC*DW-1:0]  rf_rdata,
  output logic [NSRC*DW-1:0]  src_value,
  input  logic [NFWD-1:0]     fwd_valid,
  input  logic [NFWD*AW-1:0]  fwd_addr,
  input  logic [NFWD*DW-1:0]  fwd_data,
  input  logic [NFWD-1:0]     fwd_data_ok,
  input  logic                ret_valid,
  input  logic [AW-1:0]       ret_addr,
`ifdef SB_STALL_CNT_EN
  output logic [31:0]         stall_cnt,
`endif
  output logic                sb_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NREG];
  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  src_stall;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             dest_nz;
  logic             ret_nz;
  logic             ret_same;
  logic             dest_sat;
  logic             fire;
  logic             ret_bad;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign pending[s] = (cnt[`SB_SLICE(src_addr, s, AW)] != '0);

    sb_fwd_mux #(
      .AW   (AW),
      .DW   (DW),
      .NFWD (NFWD)
    ) u_mux (
      .need        (src_need[s]),
      .addr        (`SB_SLICE(src_addr, s, AW)),
      .rf_data     (`SB_SLICE(rf_rdata, s, DW)),
      .fwd_valid   (fwd_valid),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .fwd_data_ok (fwd_data_ok),
      .pending     (pending[s]),
      .value       (`SB_SLICE(src_value, s, DW)),
      .stall       (src_stall[s])
    );
  end

  assign dest_nz  = (issue_dest != '0);
  assign ret_nz   = (ret_addr != '0);
  assign ret_same = ret_valid & ret_nz & (ret_addr == issue_dest);

  // A full counter blocks issue unless a retire frees the slot this cycle.
  assign dest_sat    = issue_we & dest_nz & (cnt[issue_dest] == CNT_FULL) & ~ret_same;
  assign issue_ready = ~(|src_stall) & ~dest_sat;
  assign fire        = issue_valid & issue_ready;
  assign ret_bad     = ret_valid & ret_nz & (cnt[ret_addr] == '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = fire & issue_we & dest_nz & (issue_dest == AW'(r));
      dec_vec[r] = ret_valid & ret_nz & (ret_addr == AW'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (ret_bad) begin
        sb_err <= 1'b1;
      end
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          cnt[r] <= '0;
        end else if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

`ifdef SB_STALL_CNT_EN
  // Survives flush on purpose: it measures lost decode cycles over the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed vectors push expected results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;

  typedef struct {
    string       name;
    logic        exp_ready;
    logic        exp_err;
    logic        chk_v0;
    logic [31:0] exp_v0;
    logic        chk_v1;
    logic [31:0] exp_v1;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic [1:0]  src_need;
  logic [9:0]  src_addr;
  logic [63:0] rf_rdata;
  logic [63:0] src_value;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [2:0]  fwd_data_ok;
  logic        ret_valid;
  logic [4:0]  ret_addr;
  logic        sb_err;
`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  reg_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_we    (issue_we),
    .issue_dest  (issue_dest),
    .src_need    (src_need),
    .src_addr    (src_addr),
    .rf_rdata    (rf_rdata),
    .src_value   (src_value),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_data_ok (fwd_data_ok),
    .ret_valid   (ret_valid),
    .ret_addr    (ret_addr),
`ifdef SB_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [4:0] a);
    return 32'h1000_0000 | {27'd0, a};
  endfunction

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle whenever one is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare({e.name, ".ready"}, {31'd0, issue_ready}, {31'd0, e.exp_ready});
        compare({e.name, ".err"}, {31'd0, sb_err}, {31'd0, e.exp_err});
        if (e.chk_v0) compare({e.name, ".v0"}, src_value[31:0], e.exp_v0);
        if (e.chk_v1) compare({e.name, ".v1"}, src_value[63:32], e.exp_v1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_dest  = '0;
    src_need    = '0;
    src_addr    = '0;
    rf_rdata    = {rf(5'd0), rf(5'd0)};
    fwd_valid   = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
    fwd_data_ok = '0;
    ret_valid   = 1'b0;
    ret_addr    = '0;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] dest,
                               input logic [1:0] need, input logic [4:0] a0, input logic [4:0] a1);
    issue_valid = v;
    issue_we    = we;
    issue_dest  = dest;
    src_need    = need;
    src_addr    = {a1, a0};
    rf_rdata    = {rf(a1), rf(a0)};
  endtask

  task automatic setFwd(input int p, input logic v, input logic [4:0] a,
                        input logic [31:0] d, input logic ok);
    fwd_valid[p]        = v;
    fwd_addr[p*5 +: 5]  = a;
    fwd_data[p*32 +: 32] = d;
    fwd_data_ok[p]      = ok;
  endtask

  task automatic checkOutput(input string nm, input logic er, input logic ee,
                             input logic c0, input logic [31:0] v0,
                             input logic c1, input logic [31:0] v1);
    exp_t e;
    e.name      = nm;
    e.exp_ready = er;
    e.exp_err   = ee;
    e.chk_v0    = c0;
    e.exp_v0    = v0;
    e.chk_v1    = c1;
    e.exp_v1    = v1;
    exp_q.push_back(e);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset", 1, 0, 1, 0, 1, 0);
    step();

    // Plain issue of r3 <- r1,r2, then the pending count must hold back a reader.
    applyStimulus(1, 1, 5'd3, 2'b11, 5'd1, 5'd2);
    checkOutput("t1_issue", 1, 0, 1, rf(5'd1), 1, rf(5'd2));
    step();
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd3, 5'd0);
    checkOutput("t1_pend", 0, 0, 0, 0, 1, 0);
    step();
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd3;
    step();
    idle();
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd3, 5'd0);
    checkOutput("t1_free", 1, 0, 1, rf(5'd3), 0, 0);
    step();
    idle();

    // Bypass priority across producer ports.
    setFwd(0, 1, 5'd5, 32'h0000_AAAA, 1);
    setFwd(1, 1, 5'd5, 32'h0000_BBBB, 1);
    setFwd(2, 1, 5'd6, 32'h0000_CCCC, 1);
    applyStimulus(1, 0, 5'd0, 2'b11, 5'd5, 5'd6);
    checkOutput("t2_prio", 1, 0, 1, 32'h0000_AAAA, 1, 32'h0000_CCCC);
    step();
    setFwd(0, 0, 5'd0, 32'h0, 0);
    checkOutput("t2_port1", 1, 0, 1, 32'h0000_BBBB, 1, 32'h0000_CCCC);
    step();
    idle();

    // Load-use: match without data stalls only when the operand is needed.
    setFwd(0, 1, 5'd4, 32'h0, 0);
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd4, 5'd0);
    checkOutput("t3_loaduse", 0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(1, 0, 5'd0, 2'b00, 5'd4, 5'd0);
    checkOutput("t3_noneed", 1, 0, 0, 0, 1, 0);
    step();
    setFwd(0, 1, 5'd4, 32'h0000_1234, 1);
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd4, 5'd0);
    checkOutput("t3_ready", 1, 0, 1, 32'h0000_1234, 0, 0);
    step();
    setFwd(1, 1, 5'd4, 32'h0000_5555, 0);
    checkOutput("t3_young_ok", 1, 0, 1, 32'h0000_1234, 0, 0);
    step();
    idle();

    // Multi-cycle writer of r7 with no bypass port.
    applyStimulus(1, 1, 5'd7, 2'b00, 5'd0, 5'd0);
    checkOutput("t4_div_issue", 1, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd7, 5'd0);
    checkOutput("t4_stall", 0, 0, 0, 0, 0, 0);
    step();
    setFwd(2, 1, 5'd7, 32'h0000_0077, 1);
    checkOutput("t4_fwd_over_cnt", 1, 0, 1, 32'h0000_0077, 0, 0);
    step();
    setFwd(2, 0, 5'd0, 32'h0, 0);
    ret_valid = 1'b1;
    ret_addr  = 5'd7;
    checkOutput("t4_ret_cycle", 0, 0, 0, 0, 0, 0);
    step();
    ret_valid = 1'b0;
    checkOutput("t4_free", 1, 0, 1, rf(5'd7), 0, 0);
    step();
    idle();

    // Counter saturation on r9.
    applyStimulus(1, 1, 5'd9, 2'b00, 5'd0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_fill", 1, 0, 0, 0, 0, 0);
      step();
    end
    checkOutput("t5_sat", 0, 0, 0, 0, 0, 0);
    step();
    ret_valid = 1'b1;
    ret_addr  = 5'd9;
    checkOutput("t5_same_ret", 1, 0, 0, 0, 0, 0);
    step();
    ret_valid = 1'b0;
    checkOutput("t5_still_sat", 0, 0, 0, 0, 0, 0);
    step();
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd9;
    repeat (3) step();
    idle();
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd9, 5'd0);
    checkOutput("t5_drained", 1, 0, 1, rf(5'd9), 0, 0);
    step();
    idle();

    // Flush beats a same-cycle issue; a later retire of r2 is then orphaned.
    applyStimulus(1, 1, 5'd2, 2'b00, 5'd0, 5'd0);
    checkOutput("t6_fill_a", 1, 0, 0, 0, 0, 0);
    step();
    checkOutput("t6_fill_b", 1, 0, 0, 0, 0, 0);
    step();
    flush = 1'b1;
    checkOutput("t6_flush_issue", 1, 0, 0, 0, 0, 0);
    step();
    idle();
    applyStimulus(1, 0, 5'd0, 2'b01, 5'd2, 5'd0);
    ret_valid = 1'b1;
    ret_addr  = 5'd2;
    checkOutput("t6_after_flush", 1, 0, 1, rf(5'd2), 0, 0);
    step();
    idle();
    applyStimulus(1, 0, 5'd0, 2'b11, 5'd0, 5'd0);
    setFwd(0, 1, 5'd0, 32'h0000_DEAD, 1);
    checkOutput("t6_r0", 1, 1, 1, 32'h0, 1, 32'h0);
    step();
    idle();
    flush = 1'b1;
    checkOutput("t6_err_sticky", 1, 1, 0, 0, 0, 0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("reset_err", 1, 0, 0, 0, 0, 0);
    step();

    repeat (2) step();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
